// File: rtl/ofdm_cp_remover.sv
// OFDM cyclic-prefix remover: finds the frame start from the detector strobe,
// drops CP_LEN prefix samples before each symbol and forwards FFT_LEN useful
// samples per symbol to the FFT through a single output register.
module ofdm_cp_remover #(
    parameter int unsigned ITEM_W  = 32,
    parameter int unsigned FFT_LEN = 1024,
    parameter int unsigned CP_LEN  = 128
) (
    input  logic              ce_clk,
    input  logic              ce_rst_n,
    input  logic [7:0]        cfg_num_symbols,
    input  logic [ITEM_W-1:0] s_axis_tdata,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [ITEM_W-1:0] m_axis_tdata,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              det_ignored,
    output logic              busy
);

    localparam int unsigned SCNT_W = $clog2(FFT_LEN + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP_CP = 2'd1,
        PASS    = 2'd2
    } state_t;

    state_t            state;
    logic [SCNT_W-1:0] samp_cnt;
    logic [7:0]        sym_cnt;
    logic [7:0]        num_sym;
    logic              rdy_en;
    logic              s_fire;
    logic              last_cp;
    logic              last_pass;

    // Ready is held low in reset; in PASS it tracks room in the output register only.
    assign s_axis_tready = rdy_en && ((state != PASS) || !m_axis_tvalid || m_axis_tready);
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign busy          = (state != IDLE);
    assign last_cp       = (samp_cnt == SCNT_W'(CP_LEN - 1));
    assign last_pass     = (samp_cnt == SCNT_W'(FFT_LEN - 1));

    // Framing state machine, counters and the output register.
    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            state         <= IDLE;
            samp_cnt      <= '0;
            sym_cnt       <= '0;
            num_sym       <= '0;
            rdy_en        <= 1'b0;
            det_ignored   <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            rdy_en      <= 1'b1;
            det_ignored <= 1'b0;

            // Output drains on its own, independent of the framing state.
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (s_fire) begin
                case (state)
                    IDLE: begin
                        if (s_axis_tuser) begin
                            num_sym <= (cfg_num_symbols == 8'd0) ? 8'd1 : cfg_num_symbols;
                            sym_cnt <= '0;
                            // The strobe sample itself is the first CP sample.
                            if (CP_LEN == 1) begin
                                state    <= PASS;
                                samp_cnt <= '0;
                            end else begin
                                state    <= SKIP_CP;
                                samp_cnt <= SCNT_W'(1);
                            end
                        end
                    end
                    SKIP_CP: begin
                        det_ignored <= s_axis_tuser;
                        if (last_cp) begin
                            state    <= PASS;
                            samp_cnt <= '0;
                        end else begin
                            samp_cnt <= samp_cnt + SCNT_W'(1);
                        end
                    end
                    PASS: begin
                        det_ignored   <= s_axis_tuser;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tuser  <= (sym_cnt == 8'd0) && (samp_cnt == '0);
                        m_axis_tlast  <= last_pass;
                        if (last_pass) begin
                            samp_cnt <= '0;
                            if (8'(sym_cnt + 8'd1) == num_sym) begin
                                state   <= IDLE;
                                sym_cnt <= '0;
                            end else begin
                                state   <= SKIP_CP;
                                sym_cnt <= sym_cnt + 8'd1;
                            end
                        end else begin
                            samp_cnt <= samp_cnt + SCNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
